// File: rtl/prga_decrypt_if.sv
`default_nettype none
// ============================================================================
// Module      : prga_decrypt_if
// Description : Handshake and RAM-port bundle between the RC4 PRGA/decrypt
//               engine (master) and its S / CT / PT memories plus the
//               controller that starts it (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface prga_decrypt_if #(
    parameter int ADDR_W = 8
);
    logic              en;
    logic              rdy;
    logic [ADDR_W-1:0] s_addr;
    logic [7:0]        s_rddata;
    logic [7:0]        s_wrdata;
    logic              s_wren;
    logic [ADDR_W-1:0] ct_addr;
    logic [7:0]        ct_rddata;
    logic [ADDR_W-1:0] pt_addr;
    logic [7:0]        pt_wrdata;
    logic              pt_wren;

    // Engine side: consumes start pulse and RAM read data, drives RAM ports
    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    // Memory / controller side
    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );
endinterface
`default_nettype wire

// File: rtl/prga_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : prga_decrypt
// Description : RC4 keystream generator / decryptor. Reads the S-box prepared
//               by init+KSA, runs the PRGA swap sequence and writes
//               pt[k] = keystream ^ ct[k] for a length-prefixed message.
//               Optional macro PRGA_ASCII_CHECK_EN: reject a plaintext byte
//               outside 0x20..0x7E (byte not written, bad_o set, abort).
// Revision    : 1.0 - initial release
// ============================================================================
module prga_decrypt #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    prga_decrypt_if.master bus
`ifdef PRGA_ASCII_CHECK_EN
    ,
    output logic           bad_o
`endif
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_LEN   = 4'd1,
        ST_RD_LEN_W = 4'd2,
        ST_WR_LEN   = 4'd3,
        ST_RD_SI    = 4'd4,
        ST_RD_SI_W  = 4'd5,
        ST_RD_SJ    = 4'd6,
        ST_RD_SJ_W  = 4'd7,
        ST_WR_SI    = 4'd8,
        ST_WR_SJ    = 4'd9,
        ST_RD_PAD   = 4'd10,
        ST_RD_PAD_W = 4'd11,
        ST_WR_PT    = 4'd12
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        si_q, si_d;     // old s[i], kept across the swap
    logic [7:0]        sj_q, sj_d;     // old s[j], kept across the swap
    logic [7:0]        pad_q, pad_d;
    logic [7:0]        ct_q, ct_d;

    logic [7:0]        w_pt;
    logic [ADDR_W-1:0] w_pad_idx;

    // Plaintext byte and keystream index come from registered old values, no re-read
    assign w_pt      = pad_q ^ ct_q;
    assign w_pad_idx = ADDR_W'(si_q) + ADDR_W'(sj_q);

`ifdef PRGA_ASCII_CHECK_EN
    logic bad_q, bad_d;
    logic w_pt_ok;

    assign w_pt_ok = (w_pt >= 8'h20) && (w_pt <= 8'h7E);
    assign bad_o   = bad_q;
`endif

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            pad_q   <= '0;
            ct_q    <= '0;
`ifdef PRGA_ASCII_CHECK_EN
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            pad_q   <= pad_d;
            ct_q    <= ct_d;
`ifdef PRGA_ASCII_CHECK_EN
            bad_q   <= bad_d;
`endif
        end
    end

    // Next-state, datapath updates and RAM port drive for each FSM step
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        len_d         = len_q;
        si_d          = si_q;
        sj_d          = sj_q;
        pad_d         = pad_q;
        ct_d          = ct_q;
`ifdef PRGA_ASCII_CHECK_EN
        bad_d         = bad_q;
`endif
        bus.rdy       = 1'b0;
        bus.s_addr    = '0;
        bus.s_wrdata  = '0;
        bus.s_wren    = 1'b0;
        bus.ct_addr   = '0;
        bus.pt_addr   = '0;
        bus.pt_wrdata = '0;
        bus.pt_wren   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
`ifdef PRGA_ASCII_CHECK_EN
                    bad_d   = 1'b0;
`endif
                    state_d = ST_RD_LEN;
                end
            end
            ST_RD_LEN: begin
                bus.ct_addr = '0;
                state_d     = ST_RD_LEN_W;
            end
            ST_RD_LEN_W: begin
                len_d   = bus.ct_rddata;
                state_d = ST_WR_LEN;
            end
            ST_WR_LEN: begin
                bus.pt_addr   = '0;
                bus.pt_wrdata = len_q;
                bus.pt_wren   = 1'b1;
                if (len_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = ADDR_W'(1);
                    i_d     = i_q + ADDR_W'(1);
                    state_d = ST_RD_SI;
                end
            end
            ST_RD_SI: begin
                bus.s_addr = i_q;
                state_d    = ST_RD_SI_W;
            end
            ST_RD_SI_W: begin
                bus.s_addr = i_q;
                si_d       = bus.s_rddata;
                j_d        = j_q + ADDR_W'(bus.s_rddata);
                state_d    = ST_RD_SJ;
            end
            ST_RD_SJ: begin
                bus.s_addr = j_q;
                state_d    = ST_RD_SJ_W;
            end
            ST_RD_SJ_W: begin
                bus.s_addr = j_q;
                sj_d       = bus.s_rddata;
                state_d    = ST_WR_SI;
            end
            ST_WR_SI: begin
                bus.s_addr   = i_q;
                bus.s_wrdata = sj_q;
                bus.s_wren   = 1'b1;
                state_d      = ST_WR_SJ;
            end
            ST_WR_SJ: begin
                // i==j rewrites the same value, leaving S unchanged
                bus.s_addr   = j_q;
                bus.s_wrdata = si_q;
                bus.s_wren   = 1'b1;
                state_d      = ST_RD_PAD;
            end
            ST_RD_PAD: begin
                bus.s_addr  = w_pad_idx;
                bus.ct_addr = k_q;
                state_d     = ST_RD_PAD_W;
            end
            ST_RD_PAD_W: begin
                bus.s_addr  = w_pad_idx;
                bus.ct_addr = k_q;
                pad_d       = bus.s_rddata;
                ct_d        = bus.ct_rddata;
                state_d     = ST_WR_PT;
            end
            ST_WR_PT: begin
                bus.pt_addr   = k_q;
                bus.pt_wrdata = w_pt;
`ifdef PRGA_ASCII_CHECK_EN
                if (!w_pt_ok) begin
                    bad_d   = 1'b1;
                    state_d = ST_IDLE;
                end else
`endif
                begin
                    bus.pt_wren = 1'b1;
                    // Terminate on k==len before incrementing so k never wraps
                    if (k_q == ADDR_W'(len_q)) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q + ADDR_W'(1);
                        i_d     = i_q + ADDR_W'(1);
                        state_d = ST_RD_SI;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
